// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter
//   Shares the single read port of an async FIFO (rclk side) between NREQ
//   consumers. One consumer at a time is granted in round-robin order and
//   receives a burst of req_len words. The arbiter paces the pop strobe
//   against FIFO empty and consumer back-pressure, and reports the outcome of
//   each burst with a one-cycle done or err pulse.
//
// Ports
//   rclk          read-domain clock
//   rrst_n        asynchronous active-low reset
//   req_i         per-consumer burst request, held until done/err
//   req_len_i     per-consumer burst length, slice i = [i*LENW +: LENW]
//   rempty_i      FIFO empty flag (registered in rclk domain)
//   rdata_i       FIFO read data at the current read address
//   rinc_o        FIFO pop strobe
//   gnt_o         one-hot grant, zero when idle and during FIN
//   out_data_o    data towards the granted consumer
//   out_valid_o   per-consumer word valid
//   out_ready_i   per-consumer word accept
//   done_o        one-cycle pulse, burst completed
//   err_o         one-cycle pulse, burst aborted by empty timeout
//   busy_o        high while a burst is granted or finishing
module fifo_rd_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int LENW  = 4,
  parameter int TMOW  = 8
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*LENW-1:0]   req_len_i,
  input  logic                   rempty_i,
  input  logic [DSIZE-1:0]       rdata_i,
  output logic                   rinc_o,
  output logic [NREQ-1:0]        gnt_o,
  output logic [DSIZE-1:0]       out_data_o,
  output logic [NREQ-1:0]        out_valid_o,
  input  logic [NREQ-1:0]        out_ready_i,
  output logic [NREQ-1:0]        done_o,
  output logic [NREQ-1:0]        err_o,
  output logic                   busy_o
);

  localparam int SELW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Last stall value before the counter would reach 2^TMOW-1.
  localparam logic [TMOW-1:0] STALL_LAST = TMOW'((1 << TMOW) - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [SELW-1:0]   rr_last_q, rr_last_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic [LENW-1:0]   remaining_q, remaining_d;
  logic [TMOW-1:0]   stall_q, stall_d;
  logic              busy_q, busy_d;

  logic              hi_found_s, lo_found_s, arb_found_s;
  logic [SELW-1:0]   hi_sel_s, lo_sel_s, arb_sel_s;
  logic [LENW-1:0]   hi_len_s, lo_len_s, arb_len_s;
  logic [NREQ-1:0]   valid_s;

  // Rotating-priority pick: lowest eligible index above rr_last_q wins,
  // otherwise the lowest eligible index at or below it (wrap-around).
  always_comb begin
    hi_found_s = 1'b0;
    hi_sel_s   = '0;
    hi_len_s   = '0;
    lo_found_s = 1'b0;
    lo_sel_s   = '0;
    lo_len_s   = '0;
    // Descending scan so the lowest matching index is written last.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i] && (req_len_i[i*LENW +: LENW] != '0)) begin
        if (SELW'(i) > rr_last_q) begin
          hi_found_s = 1'b1;
          hi_sel_s   = SELW'(i);
          hi_len_s   = req_len_i[i*LENW +: LENW];
        end else begin
          lo_found_s = 1'b1;
          lo_sel_s   = SELW'(i);
          lo_len_s   = req_len_i[i*LENW +: LENW];
        end
      end else begin
        hi_found_s = hi_found_s;
      end
    end
    arb_found_s = hi_found_s | lo_found_s;
    arb_sel_s   = hi_found_s ? hi_sel_s : lo_sel_s;
    arb_len_s   = hi_found_s ? hi_len_s : lo_len_s;
  end

  // Word handshake: valid only for the granted consumer while data exists,
  // so a pop can never happen on an empty FIFO.
  always_comb begin
    if (state_q == S_XFER) begin
      valid_s = rempty_i ? '0 : gnt_q;
    end else begin
      valid_s = '0;
    end
  end

  assign out_valid_o = valid_s;
  assign rinc_o      = |(valid_s & out_ready_i);
  assign out_data_o  = rdata_i;
  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;

  // Next-state logic for the IDLE -> XFER -> FIN burst sequence.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_last_d   = rr_last_q;
    gnt_d       = gnt_q;
    remaining_d = remaining_q;
    stall_d     = stall_q;
    busy_d      = busy_q;
    done_d      = '0;
    err_d       = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_found_s) begin
          state_d     = S_XFER;
          sel_d       = arb_sel_s;
          gnt_d       = {{(NREQ-1){1'b0}}, 1'b1} << arb_sel_s;
          remaining_d = arb_len_s;
          stall_d     = '0;
          busy_d      = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_XFER: begin
        if (rinc_o) begin
          stall_d     = '0;
          remaining_d = remaining_q - LENW'(1);
          if (remaining_q == LENW'(1)) begin
            state_d = S_FIN;
            gnt_d   = '0;
            done_d  = gnt_q;
          end else begin
            state_d = S_XFER;
          end
        end else if (rempty_i) begin
          // Only empty cycles count towards the timeout; back-pressure holds.
          stall_d = stall_q + TMOW'(1);
          if (stall_q == STALL_LAST) begin
            state_d = S_FIN;
            gnt_d   = '0;
            err_d   = gnt_q;
          end else begin
            state_d = S_XFER;
          end
        end else begin
          stall_d = stall_q;
        end
      end
      S_FIN: begin
        state_d   = S_IDLE;
        rr_last_d = sel_q;
        busy_d    = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any burst in flight silently.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      rr_last_q   <= SELW'(NREQ - 1);
      gnt_q       <= '0;
      remaining_q <= '0;
      stall_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_last_q   <= rr_last_d;
      gnt_q       <= gnt_d;
      remaining_q <= remaining_d;
      stall_q     <= stall_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Testbench for fifo_rd_arbiter: directed scenarios followed by random traffic.
// A burst-level reference model predicts grants, word transfers and done/err
// pulses; predictions go into a scoreboard queue that a separate monitor
// process drains while observing the DUT.
module tb_fifo_rd_arbiter;
  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int LENW  = 4;
  localparam int TMOW  = 8;
  localparam int TMO   = (1 << TMOW) - 1;
  localparam byte K_W  = 8'h57;
  localparam byte K_D  = 8'h44;
  localparam byte K_E  = 8'h45;

  logic                 rclk = 1'b0;
  logic                 rrst_n = 1'b1;
  logic [NREQ-1:0]      req_i = '0;
  logic [NREQ*LENW-1:0] req_len_i = '0;
  logic                 rempty_i = 1'b1;
  logic [DSIZE-1:0]     rdata_i = '0;
  logic                 rinc_o;
  logic [NREQ-1:0]      gnt_o;
  logic [DSIZE-1:0]     out_data_o;
  logic [NREQ-1:0]      out_valid_o;
  logic [NREQ-1:0]      out_ready_i = '0;
  logic [NREQ-1:0]      done_o;
  logic [NREQ-1:0]      err_o;
  logic                 busy_o;

  fifo_rd_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .LENW(LENW), .TMOW(TMOW)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .req_i(req_i), .req_len_i(req_len_i),
    .rempty_i(rempty_i), .rdata_i(rdata_i), .rinc_o(rinc_o), .gnt_o(gnt_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    byte              kind;
    int               who;
    logic [DSIZE-1:0] data;
    int               cyc;
  } ev_t;

  ev_t              exp_q[$];
  logic [DSIZE-1:0] fifo_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model: current burst owner (-1 none), words left, empty run
  int  m_cur = -1;
  int  m_last = NREQ - 1;
  int  m_left = 0;
  int  m_empties = 0;
  bit  m_closing = 1'b0;
  byte m_result = K_D;
  logic [NREQ-1:0] exp_gnt = '0;
  logic [NREQ-1:0] exp_valid = '0;
  logic            exp_busy = 1'b0;

  // environment controls
  bit pop_pending = 1'b0;
  bit rand_req = 1'b0;
  bit rand_ready = 1'b0;
  bit rearm = 1'b0;
  int push_pct = 0;
  logic [NREQ-1:0] ready_man = '1;
  logic [NREQ-1:0] clr_mask = '0;
  logic [NREQ-1:0] stage_raise = '0;
  logic [NREQ-1:0] stage_drop = '0;
  int stage_len [NREQ];

  function automatic int idx_of(input logic [NREQ-1:0] v);
    int r = -1;
    int n = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) begin
        r = i;
        n++;
      end
    end
    return (n == 1) ? r : -1;
  endfunction

  task automatic check_vec(input string name, input logic [NREQ-1:0] act, input logic [NREQ-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected events older than limit never showed up on the DUT.
  task automatic flush_missing(input int limit);
    while (exp_q.size() > 0 && exp_q[0].cyc <= limit) begin
      checks++;
      errors++;
      $display("FAIL missing_%c cyc=%0d: got nothing expected who=%0d at cyc %0d",
               exp_q[0].kind, cyc, exp_q[0].who, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic observe(input byte kind, input int who, input logic [DSIZE-1:0] data);
    ev_t e;
    flush_missing(cyc - 1);
    checks++;
    if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
      errors++;
      $display("FAIL unexpected_%c cyc=%0d: got who=%0d data=%h expected no event", kind, cyc, who, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.who != who || (kind == K_W && e.data !== data)) begin
        errors++;
        $display("FAIL event cyc=%0d: got %c who=%0d data=%h expected %c who=%0d data=%h",
                 cyc, kind, who, data, e.kind, e.who, e.data);
      end
    end
  endtask

  task automatic model_reset();
    m_cur = -1;
    m_last = NREQ - 1;
    m_closing = 1'b0;
    exp_busy = 1'b0;
    exp_gnt = '0;
    exp_valid = '0;
    exp_q.delete();
  endtask

  // Predict this cycle's outputs from the inputs, then advance the burst.
  task automatic model_step();
    int sel;
    sel = -1;
    exp_busy = (m_cur >= 0);
    exp_gnt = '0;
    exp_valid = '0;
    if (m_cur >= 0 && !m_closing) begin
      exp_gnt[m_cur] = 1'b1;
      if (!rempty_i) exp_valid[m_cur] = 1'b1;
    end
    if (m_cur < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (sel < 0 && req_i[c] && req_len_i[c*LENW +: LENW] != '0) sel = c;
      end
      if (sel >= 0) begin
        m_cur = sel;
        m_left = int'(req_len_i[sel*LENW +: LENW]);
        m_empties = 0;
        m_closing = 1'b0;
      end
    end else if (m_closing) begin
      exp_q.push_back('{m_result, m_cur, '0, cyc});
      m_last = m_cur;
      m_cur = -1;
    end else if (exp_valid[m_cur] && out_ready_i[m_cur]) begin
      exp_q.push_back('{K_W, m_cur, rdata_i, cyc});
      m_left--;
      m_empties = 0;
      if (m_left == 0) begin
        m_closing = 1'b1;
        m_result = K_D;
      end
    end else if (rempty_i) begin
      m_empties++;
      if (m_empties == TMO) begin
        m_closing = 1'b1;
        m_result = K_E;
      end
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, predict 2 ns later.
  task automatic step_cycle();
    @(negedge rclk);
    cyc++;
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_pending = 1'b0;
    if (push_pct > 0 && fifo_q.size() < 16 && $urandom_range(99) < push_pct)
      fifo_q.push_back(DSIZE'($urandom));
    for (int i = 0; i < NREQ; i++) begin
      if (clr_mask[i] && !rearm) req_i[i] = 1'b0;
      if (stage_drop[i]) req_i[i] = 1'b0;
      if (stage_raise[i]) begin
        req_i[i] = 1'b1;
        req_len_i[i*LENW +: LENW] = LENW'(stage_len[i]);
      end
      if (rand_req) begin
        if (!req_i[i] && $urandom_range(99) < 15) begin
          req_i[i] = 1'b1;
          req_len_i[i*LENW +: LENW] = LENW'($urandom_range(0, (1 << LENW) - 1));
        end else if (req_i[i] && req_len_i[i*LENW +: LENW] == '0 && $urandom_range(99) < 20) begin
          req_i[i] = 1'b0;
        end
      end
      if (rand_ready) out_ready_i[i] = ($urandom_range(99) < 75);
      else out_ready_i[i] = ready_man[i];
    end
    clr_mask = '0;
    stage_raise = '0;
    stage_drop = '0;
    rempty_i = (fifo_q.size() == 0);
    rdata_i = rempty_i ? DSIZE'($urandom) : fifo_q[0];
    #2;
    if (rrst_n) model_step();
    pop_pending = rinc_o;
    clr_mask = done_o | err_o;
  endtask

  task automatic run(input int n);
    repeat (n) step_cycle();
  endtask

  task automatic set_req(input int i, input int len);
    stage_raise[i] = 1'b1;
    stage_len[i] = len;
  endtask

  task automatic push_words(input int n);
    repeat (n) fifo_q.push_back(DSIZE'($urandom));
  endtask

  // Assert reset asynchronously, check outputs clear at once, then release.
  task automatic do_reset(input int n);
    rrst_n = 1'b0;
    #1;
    check_vec("reset_gnt", gnt_o, '0);
    check_vec("reset_valid", out_valid_o, '0);
    check_vec("reset_done", done_o, '0);
    check_vec("reset_err", err_o, '0);
    check_vec("reset_rinc", NREQ'(rinc_o), '0);
    check_vec("reset_busy", NREQ'(busy_o), '0);
    model_reset();
    req_i = '0;
    pop_pending = 1'b0;
    clr_mask = '0;
    repeat (n) @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  // Monitor: compare per-cycle outputs and drain the event scoreboard.
  always @(negedge rclk) begin
    #3;
    if (rrst_n) begin
      check_vec("gnt", gnt_o, exp_gnt);
      check_vec("busy", NREQ'(busy_o), NREQ'(exp_busy));
      check_vec("out_valid", out_valid_o, exp_valid);
      check_vec("rinc_while_empty", NREQ'(rinc_o & rempty_i), '0);
      if (rinc_o) observe(K_W, idx_of(out_valid_o & out_ready_i), out_data_o);
      if (done_o != '0) observe(K_D, idx_of(done_o), '0);
      if (err_o != '0) observe(K_E, idx_of(err_o), '0);
      flush_missing(cyc);
    end
  end

  initial begin
    #2;
    do_reset(2);

    // single burst: consumer 2, len 3, five words queued
    push_words(5);
    set_req(2, 3);
    run(8);
    check_int("burst_fifo_left", fifo_q.size(), 2);
    fifo_q.delete();

    // empty stalls then data arrives
    set_req(0, 2);
    run(10);
    push_words(3);
    run(6);
    fifo_q.delete();

    // timeout: one word then the FIFO stays empty
    push_words(1);
    set_req(1, 4);
    run(TMO + 8);

    // round-robin from reset: all requesting, len 1, FIFO well stocked
    do_reset(2);
    push_words(14);
    rearm = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1);
    run(15);
    set_req(1, 0);
    push_words(12);
    run(12);
    rearm = 1'b0;
    stage_drop = '1;
    run(6);
    fifo_q.delete();

    // back-pressure on consumer 1 for 300 cycles
    push_words(4);
    ready_man = 4'b1101;
    set_req(1, 2);
    run(300);
    ready_man = '1;
    run(6);
    fifo_q.delete();

    // reset in the middle of a stalled transfer
    push_words(4);
    ready_man = '0;
    set_req(3, 4);
    run(4);
    check_vec("midxfer_gnt_before_reset", gnt_o, 4'b1000);
    do_reset(2);
    ready_man = '1;
    fifo_q.delete();

    // random traffic
    rand_req = 1'b1;
    rand_ready = 1'b1;
    push_pct = 60;
    run(3000);
    rand_req = 1'b0;
    stage_drop = '1;
    push_pct = 90;
    run(100);
    #5;
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
